// File: rtl/sva_result_collector.sv
// rtl/sva_result_collector.sv - verdict counters, first-failure capture and timestamped record FIFO for the SVA checker
//
// Purpose:
//   Collects succ/fail/lazy verdict strobes from the SVA FSM checker.
//   Keeps saturating verdict counters and a drop counter.
//   Captures the gclk period of the first accepted failure.
//   Buffers each non-empty verdict as {mask, period_stamp} in a FIFO that is drained via valid/ready.
//   Optional macro SVA_STOP_ON_FAIL_EN adds a HALT state. The first accepted failure freezes collection and the period counter.
//
// Ports:
//   sys_clk, sys_rst            only clock; synchronous active-high reset
//   clr                         soft clear of counters, fail info and FIFO (period kept)
//   grst                        user reset level; holds period at 0 and blocks events
//   gclk_posedge_flag           one pulse per user-clock rising edge, advances period
//   evt_valid, evt_succ,
//   evt_fail, evt_lazy          verdict strobe and flags
//   rec_valid, rec_ready,
//   rec_data                    record FIFO head {fail, succ, lazy, period_stamp}
//   succ_cnt, fail_cnt,
//   lazy_cnt, drop_cnt          saturating counters
//   fail_seen, first_fail_period  sticky first-failure info
//   period                      current gclk period count (wraps)

module sva_result_collector #(
  parameter int CNT_WIDTH    = 16,
  parameter int PERIOD_WIDTH = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    clr,
  input  logic                    grst,
  input  logic                    gclk_posedge_flag,
  input  logic                    evt_valid,
  input  logic                    evt_succ,
  input  logic                    evt_fail,
  input  logic                    evt_lazy,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [PERIOD_WIDTH+2:0] rec_data,
  output logic [CNT_WIDTH-1:0]    succ_cnt,
  output logic [CNT_WIDTH-1:0]    fail_cnt,
  output logic [CNT_WIDTH-1:0]    lazy_cnt,
  output logic [CNT_WIDTH-1:0]    drop_cnt,
  output logic                    fail_seen,
  output logic [PERIOD_WIDTH-1:0] first_fail_period,
  output logic [PERIOD_WIDTH-1:0] period
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int REC_W = PERIOD_WIDTH + 3;

`ifdef SVA_STOP_ON_FAIL_EN
  typedef enum logic [1:0] {ST_HOLD = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_HOLD = 2'd0, ST_RUN = 2'd1} state_t;
`endif

  state_t state;

  logic [REC_W-1:0] mem [FIFO_DEPTH];
  // One extra pointer bit distinguishes full from empty when the index bits match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  logic [2:0] mask;
  logic       fifo_empty;
  logic       fifo_full;
  logic       accept;
  logic       pop;
  logic       push;
  logic       drop;
  logic       period_frozen;

  localparam logic [AW:0]        PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PERIOD_WIDTH-1:0] PER_ONE = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
    return (en && (v != {CNT_WIDTH{1'b1}})) ? v + CNT_ONE : v;
  endfunction

  assign mask       = {evt_fail, evt_succ, evt_lazy};
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // State is the registered value, so an event in the cycle grst rises is still accepted.
  assign accept = (state == ST_RUN) && evt_valid && (mask != 3'b000) && !clr;
  assign pop    = !fifo_empty && rec_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push   = accept && (!fifo_full || pop);
  assign drop   = accept && fifo_full && !pop;

  assign rec_valid = !fifo_empty;
  assign rec_data  = mem[rd_ptr[AW-1:0]];

`ifdef SVA_STOP_ON_FAIL_EN
  assign period_frozen = (state == ST_HALT);
`else
  assign period_frozen = 1'b0;
`endif

  // Period counter ignores clr; in HALT it freezes and grst has no effect.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      period <= '0;
    end else if (!period_frozen) begin
      if (grst) begin
        period <= '0;
      end else if (gclk_posedge_flag) begin
        period <= period + PER_ONE;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state             <= ST_HOLD;
      succ_cnt          <= '0;
      fail_cnt          <= '0;
      lazy_cnt          <= '0;
      drop_cnt          <= '0;
      fail_seen         <= 1'b0;
      first_fail_period <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      state             <= grst ? ST_HOLD : ST_RUN;
      succ_cnt          <= '0;
      fail_cnt          <= '0;
      lazy_cnt          <= '0;
      drop_cnt          <= '0;
      fail_seen         <= 1'b0;
      first_fail_period <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (!grst) state <= ST_RUN;
        end
        ST_RUN: begin
          if (grst) begin
            state <= ST_HOLD;
`ifdef SVA_STOP_ON_FAIL_EN
          end else if (accept && evt_fail) begin
            state <= ST_HALT;
`endif
          end
        end
`ifdef SVA_STOP_ON_FAIL_EN
        ST_HALT: begin
          state <= ST_HALT;
        end
`endif
        default: state <= ST_HOLD;
      endcase

      if (accept) begin
        succ_cnt <= sat_inc(succ_cnt, evt_succ);
        fail_cnt <= sat_inc(fail_cnt, evt_fail);
        lazy_cnt <= sat_inc(lazy_cnt, evt_lazy);
        if (evt_fail && !fail_seen) begin
          fail_seen         <= 1'b1;
          first_fail_period <= period;
        end
      end

      if (drop) begin
        drop_cnt <= sat_inc(drop_cnt, 1'b1);
      end

      if (push) begin
        mem[wr_ptr[AW-1:0]] <= {mask, period};
        wr_ptr              <= wr_ptr + PTR_ONE;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_sva_result_collector.sv
// tb/tb_sva_result_collector.sv - scoreboard testbench for sva_result_collector
module tb_sva_result_collector;

  localparam int D = 8;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        clr;
  logic        grst;
  logic        gclk_posedge_flag;
  logic        evt_valid;
  logic        evt_succ;
  logic        evt_fail;
  logic        evt_lazy;
  logic        rec_valid;
  logic        rec_ready;
  logic [18:0] rec_data;
  logic [15:0] succ_cnt;
  logic [15:0] fail_cnt;
  logic [15:0] lazy_cnt;
  logic [15:0] drop_cnt;
  logic        fail_seen;
  logic [15:0] first_fail_period;
  logic [15:0] period;

  always #5 sys_clk = ~sys_clk;

  sva_result_collector #(
    .CNT_WIDTH(16),
    .PERIOD_WIDTH(16),
    .FIFO_DEPTH(D)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .clr(clr),
    .grst(grst),
    .gclk_posedge_flag(gclk_posedge_flag),
    .evt_valid(evt_valid),
    .evt_succ(evt_succ),
    .evt_fail(evt_fail),
    .evt_lazy(evt_lazy),
    .rec_valid(rec_valid),
    .rec_ready(rec_ready),
    .rec_data(rec_data),
    .succ_cnt(succ_cnt),
    .fail_cnt(fail_cnt),
    .lazy_cnt(lazy_cnt),
    .drop_cnt(drop_cnt),
    .fail_seen(fail_seen),
    .first_fail_period(first_fail_period),
    .period(period)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [18:0] sb_q[$];

  bit          model_run  = 1'b0;
  bit          model_halt = 1'b0;
  logic [15:0] exp_period = '0;
  int          exp_succ = 0, exp_fail = 0, exp_lazy = 0, exp_drop = 0;
  bit          exp_seen = 1'b0;
  logic [15:0] exp_first = '0;
  logic [18:0] hold;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic model_clear();
    exp_succ = 0; exp_fail = 0; exp_lazy = 0; exp_drop = 0;
    exp_seen = 1'b0; exp_first = '0;
    model_halt = 1'b0;
    sb_q.delete();
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      gclk_posedge_flag = 1'b1;
      if (!model_halt) begin
        if (grst) exp_period = '0;
        else      exp_period = exp_period + 16'd1;
      end
      tick();
      gclk_posedge_flag = 1'b0;
    end
  endtask

  task automatic evt(input bit f, input bit s, input bit l);
    evt_valid = 1'b1;
    evt_fail  = f;
    evt_succ  = s;
    evt_lazy  = l;
    if (model_run && !model_halt && !clr && ({f, s, l} != 3'b000)) begin
      if (s) exp_succ++;
      if (f) exp_fail++;
      if (l) exp_lazy++;
      if (f && !exp_seen) begin
        exp_seen  = 1'b1;
        exp_first = exp_period;
      end
      if (sb_q.size() == D && !rec_ready) exp_drop++;
      else sb_q.push_back({f, s, l, exp_period});
`ifdef SVA_STOP_ON_FAIL_EN
      if (f && !grst) model_halt = 1'b1;
`endif
    end
    if (grst && !model_halt) exp_period = '0;
    tick();
    evt_valid = 1'b0;
    evt_fail  = 1'b0;
    evt_succ  = 1'b0;
    evt_lazy  = 1'b0;
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_succ"}, succ_cnt, exp_succ);
    check_eq({tag, "_fail"}, fail_cnt, exp_fail);
    check_eq({tag, "_lazy"}, lazy_cnt, exp_lazy);
    check_eq({tag, "_drop"}, drop_cnt, exp_drop);
    check_eq({tag, "_seen"}, fail_seen, exp_seen);
    check_eq({tag, "_first"}, first_fail_period, exp_first);
    check_eq({tag, "_period"}, period, exp_period);
  endtask

  // Pops are decided here, between edges, from the stable rec_valid/rec_ready pair.
  always @(negedge sys_clk) begin
    if (!sys_rst && !clr && rec_valid && rec_ready) begin
      if (sb_q.size() == 0) check_eq("pop_unexpected", 1, 0);
      else check_eq("pop_data", rec_data, sb_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1; clr = 1'b0; grst = 1'b0; gclk_posedge_flag = 1'b0;
    evt_valid = 1'b0; evt_succ = 1'b0; evt_fail = 1'b0; evt_lazy = 1'b0;
    rec_ready = 1'b0;
    repeat (2) tick();
    sys_rst = 1'b0;

    // Reset state
    check_eq("rst_rec_valid", rec_valid, 0);
    check_eq("rst_rec_data", rec_data, 0);
    check_counts("rst");
    tick();
    model_run = 1'b1;

    // Stamp and one-cycle latency
    pulse(3);
    check_eq("stamp_period", period, 16'd3);
    evt(0, 1, 0);
    check_eq("stamp_rec_valid", rec_valid, 1);
    check_eq("stamp_rec_data", rec_data, {3'b010, 16'd3});
    check_eq("stamp_succ_cnt", succ_cnt, 1);
    rec_ready = 1'b1;
    tick();
    check_eq("stamp_drained", rec_valid, 0);

    // First failure capture
    pulse(2);
    evt(1, 0, 0);
    pulse(4);
    evt(1, 0, 0);
    repeat (2) tick();
    check_counts("ffail");
`ifdef SVA_STOP_ON_FAIL_EN
    check_eq("ffail_cnt_const", fail_cnt, 1);
    check_eq("ffail_period_const", period, 16'd5);
`else
    check_eq("ffail_cnt_const", fail_cnt, 2);
`endif
    check_eq("ffail_first_const", first_fail_period, 16'd5);
    check_eq("ffail_drained", rec_valid, 0);

    rec_ready = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_clear();
    check_counts("clr1");

    // Overflow: 10 pushes into an 8-deep FIFO with no consumer
    repeat (10) evt(0, 0, 1);
    check_eq("ovf_drop", drop_cnt, 2);
    check_eq("ovf_lazy", lazy_cnt, 10);
    check_eq("ovf_rec_valid", rec_valid, 1);
    rec_ready = 1'b1;
    evt(0, 0, 1);
    check_eq("ovf_pushpop_drop", drop_cnt, 2);
    check_eq("ovf_pushpop_lazy", lazy_cnt, 11);
    repeat (10) tick();
    check_eq("ovf_drained", rec_valid, 0);
    check_eq("ovf_sb_empty", sb_q.size(), 0);

    // Backpressure with four queued records
    rec_ready = 1'b0;
    evt(0, 1, 0);
    pulse(1);
    evt(0, 0, 1);
    pulse(2);
    evt(0, 1, 1);
    evt(0, 1, 0);
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
    hold = rec_data;
    check_eq("bp_head", rec_data, sb_q[0]);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("bp_stable", rec_data, hold);
    end
    rec_ready = 1'b1;
    repeat (4) tick();
    check_eq("bp_drained", rec_valid, 0);
    check_counts("bp");

    // grst mid-stream, then clr with a same-cycle failure
    rec_ready = 1'b0;
    pulse(2);
    grst = 1'b1;
    evt(0, 1, 0);
    model_run = 1'b0;
    check_eq("grst_period", period, 0);
    evt(1, 0, 0);
    pulse(2);
    check_counts("grst");
    check_eq("grst_rec_valid", rec_valid, 1);
    clr = 1'b1;
    evt(1, 0, 0);
    clr = 1'b0;
    model_clear();
    check_counts("clr2");
    check_eq("clr2_rec_valid", rec_valid, 0);
    grst = 1'b0;
    tick();
    model_run = 1'b1;
    evt(0, 0, 1);
    check_eq("resume_lazy", lazy_cnt, 1);
    check_eq("resume_rec_valid", rec_valid, 1);
    rec_ready = 1'b1;
    repeat (2) tick();
    check_eq("resume_drained", rec_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
